// File: rtl/alu_writeback.sv
// alu_writeback: execute/writeback stage after the 16-bit ALU.
// Holds the architectural flag register, queues register-file writes in a
// small in-order buffer and exports a pending-destination mask for hazards.
// Build option: define ALU_WB_SKID_EN for a 2-entry buffer with a fully
// registered in_ready; otherwise a 1-entry buffer whose in_ready passes
// wb_ready through combinationally.
module alu_writeback (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  in_cmd,
  input  logic [15:0] in_result,
  input  logic [15:0] in_rflag,
  input  logic        in_wen,
  input  logic [3:0]  in_dst,
  input  logic        flag_ld,
  input  logic [15:0] flag_ld_data,
  output logic [15:0] flag,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [3:0]  wb_dst,
  output logic [15:0] wb_data,
  output logic [15:0] pending,
  output logic [15:0] retire_cnt
);

`ifdef ALU_WB_SKID_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  // Only S, Z, C, O and P exist; every other flag bit reads as zero.
  localparam logic [15:0] FLAG_MASK  = 16'hF400;
  localparam logic [15:0] ARITH_MASK = 16'hF400;  // add/adc/sub/sbb
  localparam logic [15:0] LOGIC_MASK = 16'hC400;  // S, Z, P only
  localparam logic        LAST_PTR   = 1'(DEPTH - 1);

  // Storage is always two slots; with DEPTH=1 the pointers never leave slot 0
  // so slot 1 stays empty and invalid.
  logic [1:0]       count_q, count_d;
  logic             rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [1:0]       vld_q, vld_d;
  logic [1:0][3:0]  dst_q;
  logic [1:0][15:0] data_q;
  logic [15:0]      flag_q, flag_d, upd_mask;
  logic [15:0]      cnt_q;
  logic             accept, push, pop;

  function automatic logic nxt_ptr(input logic p);
    return (p == LAST_PTR) ? 1'b0 : p + 1'b1;
  endfunction

`ifdef ALU_WB_SKID_EN
  assign in_ready = (count_q < 2'd2);
`else
  assign in_ready = (count_q == 2'd0) || wb_ready;
`endif

  assign accept = in_valid && in_ready;
  assign push   = accept && in_wen;
  assign pop    = wb_valid && wb_ready;

  // Flag next state: cmd class selects which bits follow the ALU; flag_ld wins.
  always_comb begin
    upd_mask = LOGIC_MASK;
    if (in_cmd <= 6'd15)                          upd_mask = 16'h0000;
    else if (in_cmd >= 6'd26 && in_cmd <= 6'd29)  upd_mask = ARITH_MASK;
    flag_d = flag_q;
    if (accept) flag_d = (flag_q & ~upd_mask) | (in_rflag & upd_mask);
    if (flag_ld) flag_d = flag_ld_data & FLAG_MASK;
  end

  // Buffer pointer/count/valid next state; push after pop so a same-slot
  // push+pop (DEPTH=1 replace) leaves the slot valid.
  always_comb begin
    count_d  = count_q;
    if (push && !pop)      count_d = count_q + 2'd1;
    else if (pop && !push) count_d = count_q - 2'd1;
    rd_ptr_d = pop  ? nxt_ptr(rd_ptr_q) : rd_ptr_q;
    wr_ptr_d = push ? nxt_ptr(wr_ptr_q) : wr_ptr_q;
    vld_d    = vld_q;
    if (pop)  vld_d[rd_ptr_q] = 1'b0;
    if (push) vld_d[wr_ptr_q] = 1'b1;
  end

  // State registers; reset drops every buffered write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_q   <= '0;
      cnt_q    <= '0;
      count_q  <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      vld_q    <= '0;
      dst_q    <= '0;
      data_q   <= '0;
    end else begin
      flag_q   <= flag_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      vld_q    <= vld_d;
      if (accept) cnt_q <= cnt_q + 16'd1;
      if (push) begin
        dst_q[wr_ptr_q]  <= in_dst;
        data_q[wr_ptr_q] <= in_result;
      end
    end
  end

  // Hazard mask from registered slot state only.
  always_comb begin
    pending = '0;
    for (int i = 0; i < 2; i++)
      if (vld_q[i]) pending = pending | (16'h0001 << dst_q[i]);
  end

  assign wb_valid   = (count_q != 2'd0);
  assign wb_dst     = wb_valid ? dst_q[rd_ptr_q]  : 4'd0;
  assign wb_data    = wb_valid ? data_q[rd_ptr_q] : 16'd0;
  assign flag       = flag_q;
  assign retire_cnt = cnt_q;

endmodule
